// File: rtl/regfile_sb_if.sv
// Register file access bus: one write port, two read ports, scoreboard set/query.
interface regfile_sb_if #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned ADDR_W = 4
);
   logic              wen;
   logic [ADDR_W-1:0] selRd;
   logic [WIDTH-1:0]  rd;
   logic [ADDR_W-1:0] selRa;
   logic [ADDR_W-1:0] selRb;
   logic [WIDTH-1:0]  ra;
   logic [WIDTH-1:0]  rb;
   logic              busy_set;
   logic [ADDR_W-1:0] busy_sel;
   logic              busy_ra;
   logic              busy_rb;
   logic              busy_any;

   // Decode/write-back side drives requests and consumes read data.
   modport master (
      output wen, selRd, rd, selRa, selRb, busy_set, busy_sel,
      input  ra, rb, busy_ra, busy_rb, busy_any
   );

   // Register file side.
   modport slave (
      input  wen, selRd, rd, selRa, selRb, busy_set, busy_sel,
      output ra, rb, busy_ra, busy_rb, busy_any
   );
endinterface

// File: rtl/regfile_sb.sv
// Parametrised register file with optional write-through bypass, optional
// hardwired-zero R0 and a per-register pending-write scoreboard.
module regfile_sb #(
   parameter int unsigned WIDTH    = 16,
   parameter int unsigned ADDR_W   = 4,
   parameter bit          ZERO_REG = 1'b0,
   parameter bit          BYPASS   = 1'b1
) (
   input logic          clk,
   input logic          rst,
   regfile_sb_if.slave  bus
);
   localparam int unsigned DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [DEPTH-1:0] r_pend;
   logic [DEPTH-1:0] w_pend_nxt;
   logic             w_wr_ok;
   logic             w_set_ok;
   logic             w_fwd_a;
   logic             w_fwd_b;
   logic             w_zero_a;
   logic             w_zero_b;

   // Qualify writes and scoreboard sets against the hardwired-zero register.
   always_comb begin
      w_wr_ok  = bus.wen      && !(ZERO_REG && (bus.selRd    == '0));
      w_set_ok = bus.busy_set && !(ZERO_REG && (bus.busy_sel == '0));
   end

   // Next pending state: a write clears, a new producer sets; set wins on collision.
   always_comb begin
      w_pend_nxt = r_pend;
      if (bus.wen)  w_pend_nxt[bus.selRd]    = 1'b0;
      if (w_set_ok) w_pend_nxt[bus.busy_sel] = 1'b1;
   end

   // Storage and scoreboard update; reset overrides any same-cycle write or set.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_pend <= '0;
      end else begin
         if (w_wr_ok) r_mem[bus.selRd] <= bus.rd;
         r_pend <= w_pend_nxt;
      end
   end

   // Read-port selection: zero register, then forwarded write data, then storage.
   always_comb begin
      w_zero_a = ZERO_REG && (bus.selRa == '0);
      w_zero_b = ZERO_REG && (bus.selRb == '0);
      w_fwd_a  = BYPASS && bus.wen && (bus.selRd == bus.selRa) && !rst;
      w_fwd_b  = BYPASS && bus.wen && (bus.selRd == bus.selRb) && !rst;
      bus.ra   = w_zero_a ? '0 : (w_fwd_a ? bus.rd : r_mem[bus.selRa]);
      bus.rb   = w_zero_b ? '0 : (w_fwd_b ? bus.rd : r_mem[bus.selRb]);
   end

   // Pending flags per read port, hidden while write data is being forwarded.
   always_comb begin
      bus.busy_ra  = r_pend[bus.selRa] &&
                     !(BYPASS && bus.wen && (bus.selRd == bus.selRa));
      bus.busy_rb  = r_pend[bus.selRb] &&
                     !(BYPASS && bus.wen && (bus.selRd == bus.selRb));
      bus.busy_any = |r_pend;
   end
endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default configuration (16x16, bypass) and a 32x32
// configuration with hardwired R0 and no bypass, sharing clock and reset.
module tb_regfile_sb;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   regfile_sb_if #(.WIDTH(16), .ADDR_W(4)) ifa ();
   regfile_sb_if #(.WIDTH(32), .ADDR_W(5)) ifb ();

   regfile_sb u_dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   regfile_sb #(.WIDTH(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   // 10 ns clock; inputs change on falling edges, outputs sampled 1 ns later.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic idle();
      ifa.wen = 1'b0; ifa.busy_set = 1'b0;
      ifb.wen = 1'b0; ifb.busy_set = 1'b0;
   endtask

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst = 1'b1;
      ifa.wen = 1'b0; ifa.selRd = '0; ifa.rd = '0; ifa.selRa = '0; ifa.selRb = '0;
      ifa.busy_set = 1'b0; ifa.busy_sel = '0;
      ifb.wen = 1'b0; ifb.selRd = '0; ifb.rd = '0; ifb.selRa = '0; ifb.selRb = '0;
      ifb.busy_set = 1'b0; ifb.busy_sel = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      ifa.selRa = 4'd3; ifa.selRb = 4'd15;
      #1;
      chk("a_rst_ra",  32'(ifa.ra), 32'h0);
      chk("a_rst_rb",  32'(ifa.rb), 32'h0);
      chk("a_rst_any", 32'(ifa.busy_any), 32'h0);
      chk("b_rst_any", 32'(ifb.busy_any), 32'h0);

      // Write R3 and R15 back to back, then read both.
      @(negedge clk); ifa.wen = 1'b1; ifa.selRd = 4'd3;  ifa.rd = 16'h1234;
      @(negedge clk); ifa.selRd = 4'd15; ifa.rd = 16'hFFFF;
      @(negedge clk); idle(); ifa.selRa = 4'd3; ifa.selRb = 4'd15;
      #1;
      chk("a_rd_r3",  32'(ifa.ra), 32'h1234);
      chk("a_rd_r15", 32'(ifa.rb), 32'hFFFF);
      ifa.selRa = 4'd1; ifa.selRb = 4'd14;
      #1;
      chk("a_rd_r1",  32'(ifa.ra), 32'h0);
      chk("a_rd_r14", 32'(ifa.rb), 32'h0);

      // Same-cycle forwarding to both ports.
      @(negedge clk); ifa.wen = 1'b1; ifa.selRd = 4'd5; ifa.rd = 16'hBEEF;
      ifa.selRa = 4'd5; ifa.selRb = 4'd5;
      #1;
      chk("a_byp_ra", 32'(ifa.ra), 32'hBEEF);
      chk("a_byp_rb", 32'(ifa.rb), 32'hBEEF);
      step(); idle();
      #1;
      chk("a_byp_stored", 32'(ifa.ra), 32'hBEEF);

      // Scoreboard set, then cleared by write-back with forwarding mask.
      @(negedge clk); ifa.busy_set = 1'b1; ifa.busy_sel = 4'd7;
      ifa.selRa = 4'd7; ifa.selRb = 4'd7;
      #1;
      chk("a_sb_pre_ra",  32'(ifa.busy_ra), 32'h0);
      chk("a_sb_pre_any", 32'(ifa.busy_any), 32'h0);
      step(); idle();
      #1;
      chk("a_sb_ra",  32'(ifa.busy_ra), 32'h1);
      chk("a_sb_rb",  32'(ifa.busy_rb), 32'h1);
      chk("a_sb_any", 32'(ifa.busy_any), 32'h1);
      @(negedge clk); ifa.wen = 1'b1; ifa.selRd = 4'd7; ifa.rd = 16'h0042; ifa.selRb = 4'd3;
      #1;
      chk("a_sb_wb_mask", 32'(ifa.busy_ra), 32'h0);
      chk("a_sb_wb_rb",   32'(ifa.busy_rb), 32'h0);
      chk("a_sb_wb_any",  32'(ifa.busy_any), 32'h1);
      chk("a_sb_wb_ra",   32'(ifa.ra), 32'h0042);
      step(); idle();
      #1;
      chk("a_sb_clr_ra",  32'(ifa.busy_ra), 32'h0);
      chk("a_sb_clr_any", 32'(ifa.busy_any), 32'h0);
      chk("a_sb_clr_dat", 32'(ifa.ra), 32'h0042);

      // Set/clear collision on R2: set wins, data still written.
      @(negedge clk); ifa.busy_set = 1'b1; ifa.busy_sel = 4'd2;
      @(negedge clk); ifa.wen = 1'b1; ifa.selRd = 4'd2; ifa.rd = 16'h0777;
      step(); idle(); ifa.selRa = 4'd2;
      #1;
      chk("a_col_busy", 32'(ifa.busy_ra), 32'h1);
      chk("a_col_data", 32'(ifa.ra), 32'h0777);
      // Clear R2 and set R9 in the same cycle: both apply.
      @(negedge clk); ifa.wen = 1'b1; ifa.selRd = 4'd2; ifa.rd = 16'h0888;
      ifa.busy_set = 1'b1; ifa.busy_sel = 4'd9;
      step(); idle(); ifa.selRa = 4'd2; ifa.selRb = 4'd9;
      #1;
      chk("a_dif_ra",   32'(ifa.busy_ra), 32'h0);
      chk("a_dif_rb",   32'(ifa.busy_rb), 32'h1);
      chk("a_dif_data", 32'(ifa.ra), 32'h0888);
      // Repeated set does not count: one write clears R9.
      @(negedge clk); ifa.busy_set = 1'b1; ifa.busy_sel = 4'd9;
      @(negedge clk); idle(); ifa.wen = 1'b1; ifa.selRd = 4'd9; ifa.rd = 16'h0009;
      step(); idle();
      #1;
      chk("a_rep_any", 32'(ifa.busy_any), 32'h0);

      // Reset in the middle of activity on R4.
      @(negedge clk); ifa.wen = 1'b1; ifa.selRd = 4'd4; ifa.rd = 16'h5555;
      ifa.busy_set = 1'b1; ifa.busy_sel = 4'd4;
      step(); idle(); ifa.selRa = 4'd4;
      #1;
      chk("a_mid_pre_dat",  32'(ifa.ra), 32'h5555);
      chk("a_mid_pre_busy", 32'(ifa.busy_ra), 32'h1);
      @(negedge clk); rst = 1'b1; ifa.wen = 1'b1; ifa.selRd = 4'd4; ifa.rd = 16'h1111;
      #1;
      chk("a_mid_nofwd", 32'(ifa.ra), 32'h5555);
      step(); rst = 1'b0; idle();
      #1;
      chk("a_mid_dat",  32'(ifa.ra), 32'h0);
      chk("a_mid_busy", 32'(ifa.busy_ra), 32'h0);
      chk("a_mid_any",  32'(ifa.busy_any), 32'h0);
      ifa.selRa = 4'd3;
      #1;
      chk("a_mid_r3", 32'(ifa.ra), 32'h0);

      // 32-bit, hardwired R0, no bypass: same-cycle read returns old value.
      @(negedge clk); ifb.wen = 1'b1; ifb.selRd = 5'd5; ifb.rd = 32'h0000BEEF; ifb.selRa = 5'd5;
      #1;
      chk("b_nobyp_old", ifb.ra, 32'h0);
      step(); idle();
      #1;
      chk("b_nobyp_new", ifb.ra, 32'h0000BEEF);

      // Writes and busy_set to R0 are ignored.
      @(negedge clk); ifb.wen = 1'b1; ifb.selRd = 5'd0; ifb.rd = 32'h0000AAAA;
      ifb.busy_set = 1'b1; ifb.busy_sel = 5'd0; ifb.selRa = 5'd0;
      #1;
      chk("b_z_ra_now", ifb.ra, 32'h0);
      step(); idle();
      #1;
      chk("b_z_ra",   ifb.ra, 32'h0);
      chk("b_z_busy", 32'(ifb.busy_ra), 32'h0);
      chk("b_z_any",  32'(ifb.busy_any), 32'h0);

      // Top register at full width.
      @(negedge clk); ifb.wen = 1'b1; ifb.selRd = 5'd31; ifb.rd = 32'hDEADBEEF; ifb.selRb = 5'd31;
      #1;
      chk("b_r31_old", ifb.rb, 32'h0);
      step(); idle();
      #1;
      chk("b_r31", ifb.rb, 32'hDEADBEEF);

      // Without bypass the pending flag stays visible during write-back.
      @(negedge clk); ifb.busy_set = 1'b1; ifb.busy_sel = 5'd7; ifb.selRa = 5'd7;
      step(); idle();
      #1;
      chk("b_sb_set", 32'(ifb.busy_ra), 32'h1);
      @(negedge clk); ifb.wen = 1'b1; ifb.selRd = 5'd7; ifb.rd = 32'h00000042;
      #1;
      chk("b_sb_wb_busy", 32'(ifb.busy_ra), 32'h1);
      chk("b_sb_wb_old",  ifb.ra, 32'h0);
      step(); idle();
      #1;
      chk("b_sb_clr", 32'(ifb.busy_any), 32'h0);
      chk("b_sb_dat", ifb.ra, 32'h00000042);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
